// File: rtl/instr_control_sequencer.sv
// -----------------------------------------------------------------------------
// instr_control_sequencer
//
// Hard-wired control unit for the CPU datapath. Every instruction is fetched
// in three cycles (T0..T2), then executed in a sequence that starts at T3 and
// depends on the opcode field of the latched instruction register. All
// datapath strobes are Moore outputs decoded from the state register and the
// IR fields.
//
// Ports
//   clock      : system clock, rising-edge active
//   clear      : asynchronous active-low reset
//   stop       : while high, the sequencer parks in IDLE instead of fetching
//   ir         : instruction register contents, valid from T3 onward
//   reg_out    : one-hot general-register bus drive (bit n = Rnout)
//   reg_in     : one-hot general-register load (bit n = Rnin)
//   pc_out, pc_in, mar_in, mdr_in, mdr_out, ir_in, read : fetch-path strobes
//   y_in, zlow_in, zhigh_in, zlow_out, zhigh_out, hi_in, lo_in : ALU-path strobes
//   alu_op     : ALU opcode
//   run        : high unless the processor has executed halt
//   illegal    : one-cycle pulse in T3 for an unsupported opcode
// -----------------------------------------------------------------------------
module instr_control_sequencer #(
    parameter int              IR_W      = 32,
    parameter int              OP_W      = 5,
    parameter logic [OP_W-1:0] PC_INC_OP = 5'b11111
) (
    input  logic            clock,
    input  logic            clear,
    input  logic            stop,
    input  logic [IR_W-1:0] ir,
    output logic [15:0]     reg_out,
    output logic [15:0]     reg_in,
    output logic            pc_out,
    output logic            pc_in,
    output logic            mar_in,
    output logic            mdr_in,
    output logic            mdr_out,
    output logic            ir_in,
    output logic            read,
    output logic            y_in,
    output logic            zlow_in,
    output logic            zhigh_in,
    output logic            zlow_out,
    output logic            zhigh_out,
    output logic            hi_in,
    output logic            lo_in,
    output logic [OP_W-1:0] alu_op,
    output logic            run,
    output logic            illegal
);

    // Opcode encodings.
    localparam logic [OP_W-1:0] OP_ALU_FIRST = 5'b00011;  // add
    localparam logic [OP_W-1:0] OP_ALU_LAST  = 5'b01011;  // shl
    localparam logic [OP_W-1:0] OP_MUL       = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV       = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG       = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT       = 5'b10010;
    localparam logic [OP_W-1:0] OP_NOP       = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT      = 5'b11011;

    localparam logic [15:0] REG_ONE = 16'h0001;

    typedef enum logic [3:0] {
        S_RESET,
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

    // Execute-sequence families; members of a family share one strobe pattern.
    typedef enum logic [2:0] {
        CL_ALU3,
        CL_UNARY,
        CL_MULDIV,
        CL_NOP,
        CL_HALT,
        CL_ILLEGAL
    } op_class_t;

    state_t    state;
    state_t    next_state;
    state_t    fetch_entry;
    op_class_t op_class;

    // IR fields. Only the opcode and three register selectors are used;
    // the low bits (immediates for future instructions) are ignored.
    logic [OP_W-1:0] op;
    logic [3:0]      ra;
    logic [3:0]      rb;
    logic [3:0]      rc;
    logic            unused_ir_bits;

    assign op             = ir[IR_W-1 -: OP_W];
    assign ra             = ir[IR_W-OP_W-1 -: 4];
    assign rb             = ir[IR_W-OP_W-5 -: 4];
    assign rc             = ir[IR_W-OP_W-9 -: 4];
    assign unused_ir_bits = ^ir[IR_W-OP_W-13:0];

    function automatic op_class_t classify(input logic [OP_W-1:0] opcode);
        if (opcode >= OP_ALU_FIRST && opcode <= OP_ALU_LAST) begin
            return CL_ALU3;
        end
        unique case (opcode)
            OP_NEG, OP_NOT: return CL_UNARY;
            OP_MUL, OP_DIV: return CL_MULDIV;
            OP_NOP:         return CL_NOP;
            OP_HALT:        return CL_HALT;
            default:        return CL_ILLEGAL;
        endcase
    endfunction

    assign op_class = classify(op);

    // Every path back to fetch checks stop, so a raised stop parks the
    // sequencer between instructions and never inside one.
    assign fetch_entry = stop ? S_IDLE : S_T0;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= S_RESET;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of block ordering.
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: the default assignment first means any branch that omits
        // next_state holds the current value instead of inferring a latch.
        next_state = state;
        unique case (state)
            S_RESET: next_state = fetch_entry;
            S_IDLE:  next_state = stop ? S_IDLE : S_T0;
            S_T0:    next_state = S_T1;
            S_T1:    next_state = S_T2;
            S_T2:    next_state = S_T3;
            S_T3: begin
                unique case (op_class)
                    CL_ALU3, CL_UNARY, CL_MULDIV: next_state = S_T4;
                    CL_HALT:                      next_state = S_HALT;
                    default:                      next_state = fetch_entry;
                endcase
            end
            S_T4:    next_state = (op_class == CL_UNARY) ? fetch_entry : S_T5;
            S_T5:    next_state = (op_class == CL_MULDIV) ? S_T6 : fetch_entry;
            S_T6:    next_state = fetch_entry;
            S_HALT:  next_state = S_HALT;
            default: next_state = S_RESET;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode (Moore: state register plus latched IR fields)
    // -------------------------------------------------------------------------
    always_comb begin
        reg_out   = '0;
        reg_in    = '0;
        pc_out    = 1'b0;
        pc_in     = 1'b0;
        mar_in    = 1'b0;
        mdr_in    = 1'b0;
        mdr_out   = 1'b0;
        ir_in     = 1'b0;
        read      = 1'b0;
        y_in      = 1'b0;
        zlow_in   = 1'b0;
        zhigh_in  = 1'b0;
        zlow_out  = 1'b0;
        zhigh_out = 1'b0;
        hi_in     = 1'b0;
        lo_in     = 1'b0;
        alu_op    = '0;
        run       = 1'b1;
        illegal   = 1'b0;

        unique case (state)
            // PC onto the bus, into MAR, and PC+1 into Z.
            S_T0: begin
                pc_out  = 1'b1;
                mar_in  = 1'b1;
                alu_op  = PC_INC_OP;
                zlow_in = 1'b1;
            end
            // Incremented PC back into PC while memory is read into MDR.
            S_T1: begin
                zlow_out = 1'b1;
                pc_in    = 1'b1;
                read     = 1'b1;
                mdr_in   = 1'b1;
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            S_T3: begin
                unique case (op_class)
                    CL_ALU3: begin
                        reg_out = REG_ONE << rb;
                        y_in    = 1'b1;
                    end
                    CL_UNARY: begin
                        reg_out = REG_ONE << rb;
                        alu_op  = op;
                        zlow_in = 1'b1;
                    end
                    CL_MULDIV: begin
                        reg_out = REG_ONE << ra;
                        y_in    = 1'b1;
                    end
                    CL_ILLEGAL: illegal = 1'b1;
                    default: ;  // nop and halt drive nothing in T3
                endcase
            end
            S_T4: begin
                unique case (op_class)
                    CL_ALU3: begin
                        reg_out = REG_ONE << rc;
                        alu_op  = op;
                        zlow_in = 1'b1;
                    end
                    CL_UNARY: begin
                        zlow_out = 1'b1;
                        reg_in   = REG_ONE << ra;
                    end
                    CL_MULDIV: begin
                        reg_out  = REG_ONE << rb;
                        alu_op   = op;
                        zlow_in  = 1'b1;
                        zhigh_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                unique case (op_class)
                    CL_ALU3: begin
                        zlow_out = 1'b1;
                        reg_in   = REG_ONE << ra;
                    end
                    CL_MULDIV: begin
                        zlow_out = 1'b1;
                        lo_in    = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                zhigh_out = 1'b1;
                hi_in     = 1'b1;
            end
            S_HALT:  run = 1'b0;
            default: ;  // RESET and IDLE drive nothing
        endcase
    end

endmodule

// File: tb/tb_instr_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_control_sequencer
//
// Scoreboard bench for the control sequencer. For each instruction the bench
// pushes the expected per-cycle output vector (derived from the instruction
// encoding) onto a queue, then pops one entry per clock and compares it with
// the packed DUT outputs sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_instr_control_sequencer;

    localparam logic [4:0] PC_INC = 5'b11111;

    typedef struct packed {
        logic [15:0] reg_out;
        logic [15:0] reg_in;
        logic        pc_out;
        logic        pc_in;
        logic        mar_in;
        logic        mdr_in;
        logic        mdr_out;
        logic        ir_in;
        logic        read;
        logic        y_in;
        logic        zlow_in;
        logic        zhigh_in;
        logic        zlow_out;
        logic        zhigh_out;
        logic        hi_in;
        logic        lo_in;
        logic [4:0]  alu_op;
        logic        run;
        logic        illegal;
    } ctl_t;

    logic        clock = 1'b0;
    logic        clear;
    logic        stop;
    logic [31:0] ir;

    logic [15:0] reg_out, reg_in;
    logic        pc_out, pc_in, mar_in, mdr_in, mdr_out, ir_in, read;
    logic        y_in, zlow_in, zhigh_in, zlow_out, zhigh_out, hi_in, lo_in;
    logic [4:0]  alu_op;
    logic        run, illegal;

    ctl_t obs;
    assign obs = {reg_out, reg_in, pc_out, pc_in, mar_in, mdr_in, mdr_out, ir_in,
                  read, y_in, zlow_in, zhigh_in, zlow_out, zhigh_out, hi_in, lo_in,
                  alu_op, run, illegal};

    instr_control_sequencer dut (
        .clock     (clock),
        .clear     (clear),
        .stop      (stop),
        .ir        (ir),
        .reg_out   (reg_out),
        .reg_in    (reg_in),
        .pc_out    (pc_out),
        .pc_in     (pc_in),
        .mar_in    (mar_in),
        .mdr_in    (mdr_in),
        .mdr_out   (mdr_out),
        .ir_in     (ir_in),
        .read      (read),
        .y_in      (y_in),
        .zlow_in   (zlow_in),
        .zhigh_in  (zhigh_in),
        .zlow_out  (zlow_out),
        .zhigh_out (zhigh_out),
        .hi_in     (hi_in),
        .lo_in     (lo_in),
        .alu_op    (alu_op),
        .run       (run),
        .illegal   (illegal)
    );

    always #5 clock = ~clock;

    ctl_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] pending_ir;
    logic        ir_pending = 1'b0;

    task automatic check(input string tag, input ctl_t got, input ctl_t want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic ctl_t quiet();
        ctl_t c;
        c     = '0;
        c.run = 1'b1;
        return c;
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] n);
        logic [15:0] v;
        v = 16'h0001;
        return v << n;
    endfunction

    task automatic push_fetch();
        ctl_t c;
        c = quiet(); c.pc_out = 1; c.mar_in = 1; c.alu_op = PC_INC; c.zlow_in = 1;
        exp_q.push_back(c);
        c = quiet(); c.zlow_out = 1; c.pc_in = 1; c.read = 1; c.mdr_in = 1;
        exp_q.push_back(c);
        c = quiet(); c.mdr_out = 1; c.ir_in = 1;
        exp_q.push_back(c);
    endtask

    // Queue the full expected sequence for one instruction. The IR is applied
    // after the T0 sample so the previous instruction's decode is undisturbed.
    task automatic push_instr(input logic [31:0] i);
        ctl_t       c;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        op = i[31:27]; ra = i[26:23]; rb = i[22:19]; rc = i[18:15];
        pending_ir = i;
        ir_pending = 1'b1;
        push_fetch();
        if (op >= 5'd3 && op <= 5'd11) begin
            c = quiet(); c.reg_out = oh(rb); c.y_in = 1;                          exp_q.push_back(c);
            c = quiet(); c.reg_out = oh(rc); c.alu_op = op; c.zlow_in = 1;        exp_q.push_back(c);
            c = quiet(); c.zlow_out = 1; c.reg_in = oh(ra);                       exp_q.push_back(c);
        end else if (op == 5'd17 || op == 5'd18) begin
            c = quiet(); c.reg_out = oh(rb); c.alu_op = op; c.zlow_in = 1;        exp_q.push_back(c);
            c = quiet(); c.zlow_out = 1; c.reg_in = oh(ra);                       exp_q.push_back(c);
        end else if (op == 5'd15 || op == 5'd16) begin
            c = quiet(); c.reg_out = oh(ra); c.y_in = 1;                          exp_q.push_back(c);
            c = quiet(); c.reg_out = oh(rb); c.alu_op = op; c.zlow_in = 1; c.zhigh_in = 1;
            exp_q.push_back(c);
            c = quiet(); c.zlow_out = 1; c.lo_in = 1;                             exp_q.push_back(c);
            c = quiet(); c.zhigh_out = 1; c.hi_in = 1;                            exp_q.push_back(c);
        end else if (op == 5'd26 || op == 5'd27) begin
            exp_q.push_back(quiet());
        end else begin
            c = quiet(); c.illegal = 1;                                           exp_q.push_back(c);
        end
    endtask

    task automatic run_cycles(input int n, input string tag);
        ctl_t e;
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s[%0d]: got %h expected <empty scoreboard>", tag, k, obs);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s[%0d]", tag, k), obs, e);
            end
            if (ir_pending) begin
                ir         = pending_ir;
                ir_pending = 1'b0;
            end
        end
    endtask

    task automatic run_instr(input logic [31:0] i, input string tag);
        push_instr(i);
        run_cycles(exp_q.size(), tag);
    endtask

    initial begin
        ctl_t halted;
        halted     = quiet();
        halted.run = 1'b0;

        // NOTE: stimulus is driven with blocking assignments from the initial
        // block, always away from the rising edge.
        clear = 1'b0;
        stop  = 1'b0;
        ir    = 32'h0;
        repeat (3) @(posedge clock);
        #1;
        check("reset", obs, quiet());
        @(negedge clear or negedge clock);
        clear = 1'b1;

        run_instr(32'h8A800000, "neg");
        run_instr(32'h92800000, "not");
        run_instr(32'h191A0000, "add");
        run_instr(32'h79880000, "mul");
        run_instr({5'b10000, 4'd7, 4'd9, 4'd0, 15'd0}, "div");
        run_instr({5'b01011, 4'd15, 4'd14, 4'd13, 15'd0}, "shl");
        run_instr({5'b00100, 4'd6, 4'd6, 4'd6, 15'd0}, "sub_same");
        run_instr(32'hD0000000, "nop");
        run_instr(32'hF0000000, "illegal_f");
        run_instr(32'h60000000, "illegal_0c");
        run_instr(32'h00000000, "illegal_00");

        // stop raised between instructions: park in IDLE, then resume.
        stop = 1'b1;
        repeat (4) exp_q.push_back(quiet());
        run_cycles(4, "idle");
        stop = 1'b0;
        run_instr(32'h191A0000, "add_after_stop");

        // clear asserted during T4 of add: outputs drop at once, no reg_in.
        push_instr(32'h191A0000);
        run_cycles(5, "add_abort");
        exp_q.delete();
        clear = 1'b0;
        #1;
        check("abort_reset", obs, quiet());
        @(posedge clock);
        #1;
        check("abort_hold", obs, quiet());
        @(negedge clock);
        clear = 1'b1;
        run_instr(32'h8A800000, "neg_after_abort");

        // halt: run drops after T3 and stays low until clear.
        push_instr(32'hD8000000);
        repeat (20) exp_q.push_back(halted);
        run_cycles(exp_q.size(), "halt");
        clear = 1'b0;
        #1;
        check("halt_clear", obs, quiet());
        @(negedge clock);
        clear = 1'b1;
        run_instr(32'h79880000, "mul_after_halt");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
